// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: address/data widths, the canonical NOP and
// the IF/ID pipeline register payload consumed by the decode stage.
package pipe_pkg;

    localparam int INS_ADDRESS = 9;
    localparam int INS_W       = 32;

    // addi x0, x0, 0 -- the architectural no-op used for bubbles
    localparam logic [INS_W-1:0] NOP_INSTR = 32'h00000013;

    // Word alignment: the low two bits of any fetch address are forced to zero
    localparam logic [INS_ADDRESS-1:0] ALIGN_MASK = INS_ADDRESS'(3);
    localparam logic [INS_ADDRESS-1:0] PC_STEP    = INS_ADDRESS'(4);

    typedef struct packed {
        logic [INS_ADDRESS-1:0] pc;
        logic [INS_ADDRESS-1:0] pc_plus4;
        logic [INS_W-1:0]       instr;
        logic                   valid;
    } if_id_t;

    // The IF/ID contents after reset or a squash: a NOP marked invalid
    function automatic if_id_t if_id_bubble();
        if_id_t b;
        b.pc       = '0;
        b.pc_plus4 = PC_STEP;
        b.instr    = NOP_INSTR;
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Reset and flush both load a bubble; otherwise the
// register captures new contents only when enabled (i.e. not stalled).
module if_id_reg
    import pipe_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   enable,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t q_q;
    if_id_t q_d;

    // Next contents: flush beats stall, stall holds, otherwise take the new fetch
    always_comb begin
        q_d = q_q;
        if (flush) begin
            q_d = if_id_bubble();
        end else if (enable) begin
            q_d = d;
        end
    end

    // Register with synchronous reset to a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= if_id_bubble();
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory and feeds the IF/ID register. Redirects from EX squash
// the wrong-path fetch; hazard stalls freeze both PC and IF/ID.
// The IF/ID payload layout follows the pipe_pkg widths, so the parameters
// are expected to stay at the package values.
module fetch_stage #(
    parameter int INS_ADDRESS = 9,
    parameter int INS_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [INS_ADDRESS-1:0] branch_target,
    output logic [INS_ADDRESS-1:0] imem_ra,
    input  logic [INS_W-1:0]       imem_rd,
    output logic [INS_ADDRESS-1:0] if_id_pc,
    output logic [INS_ADDRESS-1:0] if_id_pc_plus4,
    output logic [INS_W-1:0]       if_id_instr,
    output logic                   if_id_valid
);

    import pipe_pkg::*;

    logic [INS_ADDRESS-1:0] pc_q;
    logic [INS_ADDRESS-1:0] pc_d;
    logic [INS_ADDRESS-1:0] pc_plus4;
    if_id_t                 if_id_d;
    if_id_t                 if_id_q;

    // Sequential PC; the add wraps naturally modulo the address width
    assign pc_plus4 = pc_q + PC_STEP;

    // Next-PC mux: redirect (low bits dropped) beats stall, stall holds PC
    always_comb begin
        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = branch_target & ~ALIGN_MASK;
        end else if (!stall) begin
            pc_d = pc_plus4;
        end
    end

    // PC register, synchronous reset to address 0
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Payload for IF/ID: the word fetched this cycle tagged with its PC
    always_comb begin
        if_id_d          = if_id_bubble();
        if_id_d.pc       = pc_q;
        if_id_d.pc_plus4 = pc_plus4;
        if_id_d.instr    = imem_rd;
        if_id_d.valid    = 1'b1;
    end

    if_id_reg u_if_id_reg (
        .clk    (clk),
        .reset  (reset),
        .enable (~stall),
        .flush  (branch_taken),
        .d      (if_id_d),
        .q      (if_id_q)
    );

    assign imem_ra        = pc_q;
    assign if_id_pc       = if_id_q.pc;
    assign if_id_pc_plus4 = if_id_q.pc_plus4;
    assign if_id_instr    = if_id_q.instr;
    assign if_id_valid    = if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed walk through the standard
// program and corner cases, then randomized reset/stall/redirect traffic,
// all compared against a behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int MOD = 512;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic [AW-1:0] imem_ra;
    logic [DW-1:0] imem_rd;
    logic [AW-1:0] if_id_pc;
    logic [AW-1:0] if_id_pc_plus4;
    logic [DW-1:0] if_id_instr;
    logic          if_id_valid;

    logic [31:0] imem [128];

    int checks = 0;
    int errors = 0;

    // Behavioural model state: PC plus the four IF/ID fields as plain numbers
    int          m_pc;
    int          m_ifpc;
    int          m_ifpc4;
    logic [31:0] m_instr;
    int          m_valid;

    fetch_stage #(.INS_ADDRESS(AW), .INS_W(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_ra        (imem_ra),
        .imem_rd        (imem_rd),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid)
    );

    // 10 time-unit clock
    always #5 clk = ~clk;

    // Combinational instruction memory, word indexed
    assign imem_rd = imem[imem_ra[AW-1:2]];

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, advance the model by the fetch rules, and
    // compare every output just after the edge
    task automatic applyStimulus(input logic r, input logic s, input logic b,
                                 input int target);
        reset         = r;
        stall         = s;
        branch_taken  = b;
        branch_target = AW'(target);
        @(posedge clk);
        #1;
        if (r) begin
            m_pc = 0;
            m_ifpc = 0; m_ifpc4 = 4; m_instr = NOP; m_valid = 0;
        end else if (b) begin
            m_pc = ((target % MOD) / 4) * 4;
            m_ifpc = 0; m_ifpc4 = 4; m_instr = NOP; m_valid = 0;
        end else if (!s) begin
            m_ifpc  = m_pc;
            m_ifpc4 = (m_pc + 4) % MOD;
            m_instr = imem[m_pc / 4];
            m_valid = 1;
            m_pc    = (m_pc + 4) % MOD;
        end
        checkOutput("imem_ra",  32'(imem_ra),        32'(m_pc));
        checkOutput("if_pc",    32'(if_id_pc),       32'(m_ifpc));
        checkOutput("if_pc4",   32'(if_id_pc_plus4), 32'(m_ifpc4));
        checkOutput("if_instr", if_id_instr,         m_instr);
        checkOutput("if_valid", 32'(if_id_valid),    32'(m_valid));
    endtask

    initial begin
        imem[0] = 32'h00000013;
        imem[1] = 32'h00800093;
        imem[2] = 32'h00400113;
        for (int i = 3; i < 128; i++) imem[i] = $urandom;

        m_pc = 0; m_ifpc = 0; m_ifpc4 = 4; m_instr = NOP; m_valid = 0;
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;

        // Reset, including with stall and redirect asserted (reset must win)
        applyStimulus(1, 1, 1, 8'h40);
        applyStimulus(1, 0, 0, 0);
        checkOutput("rst_valid", 32'(if_id_valid), 32'd0);
        checkOutput("rst_instr", if_id_instr, NOP);
        checkOutput("rst_pc4",   32'(if_id_pc_plus4), 32'd4);
        checkOutput("rst_ra",    32'(imem_ra), 32'd0);

        // Free run through the standard program
        applyStimulus(0, 0, 0, 0);
        checkOutput("e1_pc",    32'(if_id_pc), 32'd0);
        checkOutput("e1_instr", if_id_instr, 32'h00000013);
        checkOutput("e1_valid", 32'(if_id_valid), 32'd1);
        checkOutput("e1_ra",    32'(imem_ra), 32'd4);
        applyStimulus(0, 0, 0, 0);
        checkOutput("e2_pc",    32'(if_id_pc), 32'd4);
        checkOutput("e2_instr", if_id_instr, 32'h00800093);
        checkOutput("e2_ra",    32'(imem_ra), 32'd8);
        applyStimulus(0, 0, 0, 0);
        checkOutput("e3_pc",    32'(if_id_pc), 32'd8);
        checkOutput("e3_instr", if_id_instr, 32'h00400113);
        checkOutput("e3_ra",    32'(imem_ra), 32'd12);

        // Three stalled edges at PC=12, then release
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput("stall_ra",    32'(imem_ra), 32'd12);
            checkOutput("stall_pc",    32'(if_id_pc), 32'd8);
            checkOutput("stall_instr", if_id_instr, 32'h00400113);
            checkOutput("stall_valid", 32'(if_id_valid), 32'd1);
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("release_pc", 32'(if_id_pc), 32'd12);

        // Advance to PC=20 and redirect to 0x40
        applyStimulus(0, 0, 0, 0);
        checkOutput("pc20_ra", 32'(imem_ra), 32'd20);
        applyStimulus(0, 0, 1, 32'h40);
        checkOutput("br_valid", 32'(if_id_valid), 32'd0);
        checkOutput("br_instr", if_id_instr, NOP);
        checkOutput("br_ra",    32'(imem_ra), 32'h40);
        applyStimulus(0, 0, 0, 0);
        checkOutput("tgt_pc",    32'(if_id_pc), 32'h40);
        checkOutput("tgt_valid", 32'(if_id_valid), 32'd1);

        // Redirect together with stall: redirect wins
        applyStimulus(0, 1, 1, 32'h10);
        checkOutput("brst_ra",    32'(imem_ra), 32'h10);
        checkOutput("brst_valid", 32'(if_id_valid), 32'd0);

        // Misaligned target has its low bits dropped
        applyStimulus(0, 0, 1, 32'h23);
        checkOutput("mis_ra", 32'(imem_ra), 32'h20);

        // Wrap-around at the top of the address space
        applyStimulus(0, 0, 1, 32'h1FC);
        applyStimulus(0, 0, 0, 0);
        checkOutput("wrap_pc",  32'(if_id_pc), 32'd508);
        checkOutput("wrap_pc4", 32'(if_id_pc_plus4), 32'd0);
        checkOutput("wrap_ra",  32'(imem_ra), 32'd0);

        // Back-to-back redirects keep IF/ID a bubble until the first quiet edge
        applyStimulus(0, 0, 1, 32'h80);
        applyStimulus(0, 0, 1, 32'h90);
        checkOutput("b2b_valid", 32'(if_id_valid), 32'd0);
        checkOutput("b2b_ra",    32'(imem_ra), 32'h90);
        applyStimulus(0, 0, 0, 0);
        checkOutput("b2b_pc", 32'(if_id_pc), 32'h90);

        // Redirect to the current PC refetches it
        applyStimulus(0, 0, 1, 32'h94);
        applyStimulus(0, 0, 0, 0);
        checkOutput("self_pc", 32'(if_id_pc), 32'h94);

        // Reset mid-stream at PC=0x30 with a valid instruction in IF/ID
        applyStimulus(0, 0, 1, 32'h2C);
        applyStimulus(0, 0, 0, 0);
        checkOutput("pre_rst_ra",    32'(imem_ra), 32'h30);
        checkOutput("pre_rst_valid", 32'(if_id_valid), 32'd1);
        applyStimulus(1, 0, 0, 0);
        checkOutput("mid_rst_ra",    32'(imem_ra), 32'd0);
        checkOutput("mid_rst_valid", 32'(if_id_valid), 32'd0);
        checkOutput("mid_rst_instr", if_id_instr, NOP);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 99) < 3),
                          ($urandom_range(0, 99) < 25),
                          ($urandom_range(0, 99) < 15),
                          int'($urandom_range(0, MOD - 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
